functional_unit: RTL and testbench

Execution stage between a reservation station and the common data bus (CDB), instantiated once as the adder and once as the multiplier. It accepts one issued operation per cycle from its reservation station. Each operation moves through a fixed-latency pipeline, then waits in a small result queue until the CDB arbiter grants the bus. It then broadcasts the 3-bit tag and 32-bit result that reservation stations and the reorder buffer snoop. A credit rule on `functional_unit_ready` guarantees no accepted operation is ever lost.

---
 rtl/ooo_pkg.sv | 30 +++
 rtl/result_fifo.sv | 73 +++++++
 rtl/functional_unit.sv | 123 ++++++++++++
 tb/tb_functional_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order execution slice: tags, data words and
// the tag/value pair that a functional unit broadcasts on the CDB.
package ooo_pkg;

  typedef logic [2:0]  tag_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    tag_t  tag;
    word_t value;
  } fu_result_t;

  localparam int TAG_UNIT_BIT = 2;

  // Result queues hold at most four entries, so pointer and count widths are fixed.
  localparam int FU_MAX_DEPTH = 4;
  localparam int FU_PTR_W     = 2;
  localparam int FU_CNT_W     = 3;

  function automatic word_t fu_compute(input logic is_mul, input word_t op_a, input word_t op_b);
    word_t res;
    if (is_mul) begin
      res = op_a * op_b;
    end else begin
      res = op_a + op_b;
    end
    return res;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small FIFO of fu_result_t entries that holds finished results until the
// CDB arbiter grants the bus; clear empties it synchronously.
module result_fifo
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                push,
  input  fu_result_t          push_data,
  input  logic                pop,
  output logic [FU_CNT_W-1:0] count,
  output fu_result_t          head
);

  fu_result_t          mem_r [FU_MAX_DEPTH];
  logic [FU_PTR_W-1:0] wr_ptr_r;
  logic [FU_PTR_W-1:0] rd_ptr_r;
  logic [FU_CNT_W-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  function automatic logic [FU_PTR_W-1:0] ptr_inc(input logic [FU_PTR_W-1:0] ptr);
    logic [FU_PTR_W-1:0] nxt;
    if (ptr == FU_PTR_W'(DEPTH - 1)) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

  // Guard push/pop so a stray strobe can never corrupt the occupancy count.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    pop_s  = pop && (count_r != 3'd0);
    push_s = push && ((count_r < FU_CNT_W'(DEPTH)) || pop_s);
  end

  // Storage; entries need no reset because head is only used while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; clear wins over any push or pop.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/functional_unit.sv
// Fixed-latency execution unit (adder or multiplier) feeding a result queue
// that drains onto the CDB; issue credit guarantees no accepted op is lost.
module functional_unit
  import ooo_pkg::*;
#(
  parameter int unsigned ADD_OR_MUL  = 0,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        new_instruction,
  input  logic [2:0]  instruction_tag,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        functional_unit_ready,
  output logic        cdb_request,
  input  logic        cdb_grant,
  output logic        bus_valid_output,
  output logic [2:0]  broadcasted_tag,
  output logic [31:0] broadcasted_value,
  output logic        issue_overflow
);

  logic                accept_s;
  logic                fifo_clear_s;
  logic                pop_s;
  logic [LATENCY-1:0]  stage_valid_s;
  logic [3:0]          inflight_s;
  logic [4:0]          occupancy_s;
  logic [FU_CNT_W-1:0] count_s;
  fu_result_t          head_s;
  logic                overflow_r;

  // Credit check: pipeline plus queue occupancy must leave room for one more result.
  always_comb begin
    inflight_s            = 4'd0;
    occupancy_s           = 5'd0;
    accept_s              = 1'b0;
    inflight_s            = 4'($countones(stage_valid_s));
    occupancy_s           = {1'b0, inflight_s} + {2'b00, count_s};
    functional_unit_ready = occupancy_s < 5'(QUEUE_DEPTH);
    accept_s              = new_instruction && functional_unit_ready && !flush;
  end

  for (genvar g = 0; g < LATENCY; g++) begin : gen_stage
    logic       valid_r;
    fu_result_t data_r;
    logic       valid_in_s;
    fu_result_t data_in_s;

    if (g == 0) begin : gen_first
      assign valid_in_s = accept_s;
      assign data_in_s  = {instruction_tag, fu_compute(ADD_OR_MUL != 32'd0, a, b)};
    end else begin : gen_next
      assign valid_in_s = gen_stage[g-1].valid_r;
      assign data_in_s  = gen_stage[g-1].data_r;
    end

    // Stages advance every cycle and never stall; flush only drops the valid bit.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_r <= 1'b0;
        data_r  <= {3'd0, 32'd0};
      end else if (flush) begin
        valid_r <= 1'b0;
        data_r  <= data_r;
      end else begin
        valid_r <= valid_in_s;
        data_r  <= valid_in_s ? data_in_s : data_r;
      end
    end

    assign stage_valid_s[g] = valid_r;
  end

  assign fifo_clear_s = reset || flush;
  assign pop_s        = cdb_grant && (count_s != 3'd0);

  result_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .clear     (fifo_clear_s),
    .push      (gen_stage[LATENCY-1].valid_r),
    .push_data (gen_stage[LATENCY-1].data_r),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  // Sticky overflow: an issue refused for lack of credit is lost, so remember it until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (new_instruction && !functional_unit_ready) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Broadcast the queue head; tag and value read as zero while the queue is empty.
  always_comb begin
    cdb_request       = 1'b0;
    bus_valid_output  = 1'b0;
    broadcasted_tag   = 3'd0;
    broadcasted_value = 32'd0;
    cdb_request       = count_s != 3'd0;
    bus_valid_output  = cdb_grant && cdb_request;
    if (cdb_request) begin
      broadcasted_tag   = head_s.tag;
      broadcasted_value = head_s.value;
    end else begin
      broadcasted_tag   = 3'd0;
      broadcasted_value = 32'd0;
    end
  end

  assign issue_overflow = overflow_r;

endmodule

// File: tb/tb_functional_unit.sv
// Randomised and directed bench for functional_unit: three instances (adder
// L2/Q2, multiplier L4/Q4, adder L2/Q4) checked against a queue-based model.
module tb_functional_unit;
  import ooo_pkg::*;

  localparam int MUL_U [3] = '{0, 1, 0};
  localparam int LAT_U [3] = '{2, 4, 2};
  localparam int QD_U  [3] = '{2, 4, 4};

  logic       clk = 1'b0;
  logic       reset, flush, new_instruction;
  logic [1:0] slot;
  word_t      a, b;
  logic [2:0] grant;
  logic [2:0] rdy, req, bvo, ovf;
  tag_t       btag [3];
  word_t      bval [3];

  always #5 clk = ~clk;

  functional_unit #(.ADD_OR_MUL(0), .LATENCY(2), .QUEUE_DEPTH(2)) u_add (
    .clk(clk), .reset(reset), .flush(flush), .new_instruction(new_instruction),
    .instruction_tag({1'b0, slot}), .a(a), .b(b), .functional_unit_ready(rdy[0]),
    .cdb_request(req[0]), .cdb_grant(grant[0]), .bus_valid_output(bvo[0]),
    .broadcasted_tag(btag[0]), .broadcasted_value(bval[0]), .issue_overflow(ovf[0]));

  functional_unit #(.ADD_OR_MUL(1), .LATENCY(4), .QUEUE_DEPTH(4)) u_mul (
    .clk(clk), .reset(reset), .flush(flush), .new_instruction(new_instruction),
    .instruction_tag({1'b1, slot}), .a(a), .b(b), .functional_unit_ready(rdy[1]),
    .cdb_request(req[1]), .cdb_grant(grant[1]), .bus_valid_output(bvo[1]),
    .broadcasted_tag(btag[1]), .broadcasted_value(bval[1]), .issue_overflow(ovf[1]));

  functional_unit #(.ADD_OR_MUL(0), .LATENCY(2), .QUEUE_DEPTH(4)) u_fast (
    .clk(clk), .reset(reset), .flush(flush), .new_instruction(new_instruction),
    .instruction_tag({1'b0, slot}), .a(a), .b(b), .functional_unit_ready(rdy[2]),
    .cdb_request(req[2]), .cdb_grant(grant[2]), .bus_valid_output(bvo[2]),
    .broadcasted_tag(btag[2]), .broadcasted_value(bval[2]), .issue_overflow(ovf[2]));

  // Model: every accepted op waits in a per-unit list until its due cycle, then leaves in order.
  typedef struct {
    tag_t  tag;
    word_t val;
    int    due;
  } exp_t;

  exp_t pend [3][$];
  bit   ovf_m [3];
  int   cyc;
  int   errors;
  int   checks;
  bit   chk_en;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic word_t ref_result(input int mul, input word_t x, input word_t y);
    logic [63:0] wide;
    if (mul != 0) wide = {32'd0, x} * {32'd0, y};
    else          wide = {32'd0, x} + {32'd0, y};
    return wide[31:0];
  endfunction

  task automatic compare_all();
    bit vis;
    for (int u = 0; u < 3; u++) begin
      vis = (pend[u].size() != 0) && (pend[u][0].due <= cyc);
      check_val($sformatf("u%0d_ready", u), rdy[u], pend[u].size() < QD_U[u]);
      check_val($sformatf("u%0d_request", u), req[u], vis);
      check_val($sformatf("u%0d_bus_valid", u), bvo[u], grant[u] && vis);
      check_val($sformatf("u%0d_tag", u), btag[u], vis ? pend[u][0].tag : 3'd0);
      check_val($sformatf("u%0d_value", u), bval[u], vis ? pend[u][0].val : 32'd0);
      check_val($sformatf("u%0d_overflow", u), ovf[u], ovf_m[u]);
    end
  endtask

  task automatic model_edge();
    bit   vis;
    bit   ok;
    exp_t e;
    for (int u = 0; u < 3; u++) begin
      vis = (pend[u].size() != 0) && (pend[u][0].due <= cyc);
      ok  = pend[u].size() < QD_U[u];
      if (reset) begin
        pend[u].delete();
        ovf_m[u] = 1'b0;
      end else begin
        if (new_instruction && !ok) ovf_m[u] = 1'b1;
        if (flush) begin
          pend[u].delete();
        end else begin
          if (grant[u] && vis) void'(pend[u].pop_front());
          if (new_instruction && ok) begin
            e.tag = {(MUL_U[u] != 0), slot};
            e.val = ref_result(MUL_U[u], a, b);
            e.due = cyc + 1 + LAT_U[u];
            pend[u].push_back(e);
          end
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic ni, input logic [1:0] sl,
                      input word_t av, input word_t bw, input logic [2:0] g);
    reset = rst; flush = fl; new_instruction = ni; slot = sl; a = av; b = bw; grant = g;
    #2;
    if (chk_en) compare_all();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic [2:0] g);
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, g);
  endtask

  task automatic iss(input logic [1:0] sl, input word_t av, input word_t bw, input logic [2:0] g);
    step(1'b0, 1'b0, 1'b1, sl, av, bw, g);
  endtask

  initial begin
    int    cnt;
    logic  r, f, n;
    word_t ra, rb;
    errors = 0; checks = 0; cyc = 0; chk_en = 1'b0;
    reset = 1'b1; flush = 1'b0; new_instruction = 1'b0; slot = 2'd0;
    a = 32'd0; b = 32'd0; grant = 3'b111;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'b111);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'b111);
    check_val("reset_ready", rdy, 3'b111);
    check_val("reset_request", req, 3'b000);
    check_val("reset_bus_valid", bvo, 3'b000);
    check_val("reset_tag", btag[0], 3'd0);
    check_val("reset_value", bval[0], 32'd0);
    check_val("reset_overflow", ovf, 3'b000);
    idle(3'b111);

    // Single add: bus valid exactly two cycles after the accepting edge.
    iss(2'd1, 32'd5, 32'd7, 3'b111);
    check_val("add_early1", bvo[0], 1'b0);
    idle(3'b111);
    check_val("add_early2", bvo[0], 1'b0);
    idle(3'b111);
    check_val("add_valid", bvo[0], 1'b1);
    check_val("add_tag", btag[0], 3'b001);
    check_val("add_value", bval[0], 32'd12);
    idle(3'b111);
    check_val("add_once", bvo[0], 1'b0);
    idle(3'b111);
    check_val("mul_valid", bvo[1], 1'b1);
    check_val("mul_tag", btag[1], 3'b101);
    check_val("mul_value", bval[1], 32'd35);
    for (int i = 0; i < 3; i++) idle(3'b111);

    // Truncating multiply and modular add.
    iss(2'd2, 32'hFFFF_FFFF, 32'd2, 3'b111);
    iss(2'd3, 32'hFFFF_FFFF, 32'd1, 3'b111);
    idle(3'b111);
    check_val("add_carry_value", bval[0], 32'd1);
    idle(3'b111);
    check_val("add_wrap_value", bval[0], 32'd0);
    check_val("add_wrap_tag", btag[0], 3'b011);
    idle(3'b111);
    check_val("mul_trunc_value", bval[1], 32'hFFFF_FFFE);
    check_val("mul_trunc_tag", btag[1], 3'b110);
    for (int i = 0; i < 4; i++) idle(3'b111);

    // Grant withheld: credit runs out after two accepts, then an overflowing issue.
    iss(2'd0, 32'd10, 32'd20, 3'b000);
    check_val("credit_one", rdy[0], 1'b1);
    iss(2'd1, 32'd30, 32'd40, 3'b000);
    check_val("credit_none", rdy[0], 1'b0);
    for (int i = 0; i < 3; i++) idle(3'b000);
    check_val("stalled_request", req[0], 1'b1);
    check_val("stalled_bus", bvo[0], 1'b0);
    iss(2'd2, 32'd1, 32'd1, 3'b000);
    check_val("overflow_set", ovf[0], 1'b1);
    idle(3'b111);
    check_val("drain_second_valid", bvo[0], 1'b1);
    check_val("drain_second_tag", btag[0], 3'b001);
    check_val("drain_second_value", bval[0], 32'd70);
    idle(3'b111);
    check_val("drain_empty", req[0], 1'b0);
    check_val("drain_ready", rdy[0], 1'b1);
    for (int i = 0; i < 5; i++) idle(3'b111);

    // Flush with one result queued and one still in the pipeline.
    iss(2'd0, 32'd100, 32'd1, 3'b000);
    idle(3'b000);
    iss(2'd1, 32'd200, 32'd2, 3'b000);
    check_val("preflush_request", req[0], 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 3'b000);
    check_val("flush_request", req, 3'b000);
    check_val("flush_ready", rdy, 3'b111);
    check_val("flush_keeps_overflow", ovf[0], 1'b1);
    for (int i = 0; i < 6; i++) idle(3'b111);

    // Back-to-back issue on the deep-queue adder: one broadcast per cycle.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      iss(2'(i), 32'(i), 32'd1000, 3'b111);
      cnt += int'(bvo[2]);
    end
    for (int i = 0; i < 5; i++) begin
      idle(3'b111);
      cnt += int'(bvo[2]);
    end
    check_val("stream_count", 64'(cnt), 64'd10);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 39) == 0);
      n  = ($urandom_range(0, 9) < 6);
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : word_t'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 32'd1 : word_t'($urandom);
      step(r, f, n, 2'($urandom_range(0, 3)), ra, rb, 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
